wsp_sequencer: RTL and testbench
================================

Name: wsp_sequencer

Overview:
- Command-driven controller that drives the IEEE 1500 Wrapper Serial Port (WSP) of the s349 wrapper.
- Generates SelectWIR, CaptureWR, ShiftWR, UpdateWR, WRSTN and the serial input. Collects the serial output into a parallel response word.
- Sits directly upstream of the wrapper top, replacing hand-driven WSP pins.
- Test software issues "load WIR" / "scan DR" / "reset wrapper" commands through a valid/ready handshake.

Parameters:
- MAX_LEN, 20, widest register scanned (WBR chain is 20 cells); width of cmd_data/rsp_data
- LEN_W, 5, width of cmd_len; must satisfy 2^LEN_W > MAX_LEN
- RST_CYC, 2, number of cycles WRSTN is held low by a reset command

Ports:
- WRCK  in  1  clock; all logic on rising edge
- WRST  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  controller can accept a command
- cmd_op  in  2  00 = WIR scan, 01 = DR scan, 10 = wrapper reset, 11 = reserved (treated as no-op)
- cmd_len  in  LEN_W  number of shift cycles
- cmd_data  in  MAX_LEN  bits to shift in, bit 0 first
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  MAX_LEN  bits shifted out, first-out bit at index 0
- SelectWIR  out  1  to wrapper: 1 selects the WIR
- CaptureWR  out  1  to wrapper capture strobe
- ShiftWR  out  1  to wrapper shift enable
- UpdateWR  out  1  to wrapper update strobe
- WRSTN  out  1  to wrapper reset, active-low
- WSI  out  1  serial data to wrapper (wir_wsi / chain input)
- WSO  in  1  serial data from wrapper (wir_wso / chain output)
- busy  out  1  high in any state other than IDLE

Behaviour:
- Clocking and reset: one clock (WRCK); reset WRST is synchronous, active-high.
- While WRST is high, every output is held at its reset value:
  - WRSTN = 0
  - cmd_ready = 0
  - rsp_valid = 0
  - rsp_data = 0
  - SelectWIR = CaptureWR = ShiftWR = UpdateWR = WSI = busy = 0
- First cycle after WRST falls: IDLE, with cmd_ready = 1 and WRSTN = 1.
- Reset asserted mid-operation aborts the command. No partial response is produced. No UpdateWR pulse is issued.
- States: IDLE, CAPTURE, SHIFT, UPDATE, DONE, WRESET.
- IDLE:
  - cmd_ready = 1; all WSP strobes 0.
  - Handshake is cmd_valid & cmd_ready. On handshake, latch op, len and data.
  - Effective length L = min(cmd_len, MAX_LEN).
  - Next state: op 00/01 -> CAPTURE; op 10 -> WRESET; op 11 -> IDLE (consumed, no response).
- CAPTURE: exactly 1 cycle with CaptureWR = 1. Next state: SHIFT if L > 0, else UPDATE.
- SHIFT:
  - Exactly L cycles with ShiftWR = 1.
  - On shift cycle k (0..L-1): WSI = cmd_data[k].
  - At the end of cycle k, WSO is sampled into rsp_data[k].
  - Bits L..MAX_LEN-1 of rsp_data are 0.
  - Shift counter is LEN_W wide and counts up from 0; leave SHIFT when the counter = L-1.
- UPDATE: exactly 1 cycle with UpdateWR = 1. Next state: DONE.
- SelectWIR:
  - Equals (op == 00) throughout CAPTURE, SHIFT and UPDATE.
  - Driven 0 in IDLE, DONE and WRESET.
  - Never changes while any strobe is active.
- DONE:
  - rsp_valid = 1; rsp_data held stable.
  - Leave on rsp_valid & rsp_ready -> IDLE (rsp_valid drops next cycle).
  - Backpressure is unbounded. cmd_ready stays 0 until the response is taken.
- WRESET:
  - WRSTN = 0 for RST_CYC cycles, then IDLE.
  - No response is produced and rsp_data is unchanged.
- Strobe exclusivity: at most one of CaptureWR / ShiftWR / UpdateWR is high in any cycle.
- WSI is 0 whenever ShiftWR = 0.
- Command-to-response latency: L + 3 cycles from the handshake edge to the first rsp_valid = 1 cycle.
- Back-to-back commands: the earliest next handshake is the cycle after the response handshake.

Test Plan:
- WIR load: op=00, len=3, data=3'b101, WSO tied to delayed WSI model of a 3-bit WIR pre-loaded 3'b010 -> one CaptureWR, ShiftWR for 3 cycles, WSI sequence 1,0,1, SelectWIR=1 throughout, one UpdateWR, rsp_data=3'b010 at cycle 6.
- Full DR scan: op=01, len=20, data=20'hA5C3E, 20-bit loopback shift-register model initialised to 20'h0F0F0 -> ShiftWR high 20 cycles, SelectWIR=0, rsp_data=20'h0F0F0; a second scan then returns 20'hA5C3E.
- Zero/overlong length: len=0 -> CaptureWR then UpdateWR on consecutive cycles, no ShiftWR, rsp_data=0. len=31 -> exactly 20 shift cycles.
- Backpressure: hold rsp_ready=0 for 10 cycles after rsp_valid -> rsp_valid and rsp_data stable, cmd_ready=0, and a cmd_valid offered meanwhile is not accepted.
- Reset mid-shift: assert WRST on shift cycle 7 of a len=20 scan -> next cycle all strobes 0, WRSTN=0, rsp_valid=0; after release, IDLE with cmd_ready=1 and no UpdateWR ever seen.
- Wrapper reset and reserved op: op=10 -> WRSTN low exactly 2 cycles, no rsp_valid. op=11 -> accepted, busy stays 0, no strobes.

Source files
------------

// File: rtl/wsp_sequencer.sv
// Command-driven IEEE 1500 WSP controller: turns WIR/DR scan and wrapper-reset commands into
// SelectWIR/CaptureWR/ShiftWR/UpdateWR/WRSTN/WSI activity and gathers WSO into a response word.
module wsp_sequencer #(
    parameter int unsigned MAX_LEN = 20,
    parameter int unsigned LEN_W   = 5,
    parameter int unsigned RST_CYC = 2
) (
    input  logic               WRCK,
    input  logic               WRST,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               SelectWIR,
    output logic               CaptureWR,
    output logic               ShiftWR,
    output logic               UpdateWR,
    output logic               WRSTN,
    output logic               WSI,
    input  logic               WSO,
    output logic               busy
);

    typedef enum logic [2:0] {
        StIdle,
        StCapture,
        StShift,
        StUpdate,
        StDone,
        StWreset
    } state_e;

    state_e               state_q, state_d;
    logic [1:0]           op_q, op_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [LEN_W-1:0]     cnt_q, cnt_d;
    logic [MAX_LEN-1:0]   data_q, data_d;
    logic [MAX_LEN-1:0]   rsp_q, rsp_d;
    logic [LEN_W-1:0]     eff_len;
    logic                 hs;

    assign hs      = cmd_valid & cmd_ready;
    assign eff_len = (cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len;

    always_ff @(posedge WRCK) begin
        if (WRST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (hs) begin
                    case (cmd_op)
                        2'b00, 2'b01: state_d = StCapture;
                        2'b10:        state_d = StWreset;
                        default:      state_d = StIdle;
                    endcase
                end
            end
            StCapture: state_d = (len_q != '0) ? StShift : StUpdate;
            StShift:   if (cnt_q == len_q - LEN_W'(1)) state_d = StUpdate;
            StUpdate:  state_d = StDone;
            StDone:    if (rsp_ready) state_d = StIdle;
            StWreset:  if (cnt_q == LEN_W'(RST_CYC - 1)) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Outputs are forced to their reset values for every cycle WRST is high, including the
    // first one, so an abort never leaks a strobe to the wrapper.
    always_comb begin
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        SelectWIR = 1'b0;
        CaptureWR = 1'b0;
        ShiftWR   = 1'b0;
        UpdateWR  = 1'b0;
        WRSTN     = 1'b0;
        WSI       = 1'b0;
        busy      = 1'b0;
        rsp_data  = '0;
        if (!WRST) begin
            WRSTN    = (state_q != StWreset);
            busy     = (state_q != StIdle);
            rsp_data = rsp_q;
            case (state_q)
                StIdle:    cmd_ready = 1'b1;
                StCapture: begin
                    CaptureWR = 1'b1;
                    SelectWIR = (op_q == 2'b00);
                end
                StShift: begin
                    ShiftWR   = 1'b1;
                    SelectWIR = (op_q == 2'b00);
                    WSI       = data_q[cnt_q];
                end
                StUpdate: begin
                    UpdateWR  = 1'b1;
                    SelectWIR = (op_q == 2'b00);
                end
                StDone:    rsp_valid = 1'b1;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge WRCK) begin
        if (WRST) begin
            op_q   <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
            data_q <= '0;
            rsp_q  <= '0;
        end else begin
            op_q   <= op_d;
            len_q  <= len_d;
            cnt_q  <= cnt_d;
            data_q <= data_d;
            rsp_q  <= rsp_d;
        end
    end

    always_comb begin
        op_d   = op_q;
        len_d  = len_q;
        cnt_d  = cnt_q;
        data_d = data_q;
        rsp_d  = rsp_q;
        if (hs) begin
            op_d   = cmd_op;
            len_d  = eff_len;
            data_d = cmd_data;
            cnt_d  = '0;
            // Only scans produce a response; reset and reserved commands keep the old word.
            if (!cmd_op[1]) begin
                rsp_d = '0;
            end
        end
        case (state_q)
            StCapture: cnt_d = '0;
            StShift: begin
                rsp_d[cnt_q] = WSO;
                cnt_d        = cnt_q + LEN_W'(1);
            end
            StWreset:  cnt_d = cnt_q + LEN_W'(1);
            default:   ;
        endcase
    end

endmodule

// File: tb/tb_wsp_sequencer.sv
// Directed bench for wsp_sequencer: a table of scans against a serial register model, plus
// hand-written backpressure, wrapper-reset, reserved-op and mid-shift reset sequences.
module tb_wsp_sequencer;

    logic        WRCK = 1'b0;
    logic        WRST = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [4:0]  cmd_len = 5'd0;
    logic [19:0] cmd_data = 20'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [19:0] rsp_data;
    logic        SelectWIR, CaptureWR, ShiftWR, UpdateWR, WRSTN, WSI, WSO, busy;

    int checks = 0;
    int failures = 0;

    // Wrapper register model: mlen-bit shift register, WSO is bit 0, WSI enters at the top.
    logic [19:0] chain = 20'h0;
    logic        model_load = 1'b0;
    logic [19:0] model_init = 20'h0;
    int          mlen = 20;

    always #5 WRCK = ~WRCK;

    wsp_sequencer #(
        .MAX_LEN(20),
        .LEN_W  (5),
        .RST_CYC(2)
    ) dut (
        .WRCK     (WRCK),
        .WRST     (WRST),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_len  (cmd_len),
        .cmd_data (cmd_data),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .SelectWIR(SelectWIR),
        .CaptureWR(CaptureWR),
        .ShiftWR  (ShiftWR),
        .UpdateWR (UpdateWR),
        .WRSTN    (WRSTN),
        .WSI      (WSI),
        .WSO      (WSO),
        .busy     (busy)
    );

    function automatic logic [19:0] shifted(input logic [19:0] c, input logic b, input int m);
        logic [19:0] t;
        t = c >> 1;
        t[m-1] = b;
        return t;
    endfunction

    assign WSO = chain[0];

    always @(posedge WRCK) begin
        if (model_load) chain <= model_init;
        else if (ShiftWR) chain <= shifted(chain, WSI, mlen);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  len;
        logic [19:0] data;
        logic        load;
        int          mlen;
        logic [19:0] init;
        logic [19:0] exp_rsp;
        int          exp_shifts;
    } vec_t;

    task automatic run_scan(input vec_t v);
        int ncap, nshift, nupd, lat;
        logic wsi_ok, sel_ok, excl_ok, done;
        ncap = 0; nshift = 0; nupd = 0; lat = 0;
        wsi_ok = 1'b1; sel_ok = 1'b1; excl_ok = 1'b1; done = 1'b0;
        @(negedge WRCK);
        chk("ready_before_cmd", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_op = v.op; cmd_len = v.len; cmd_data = v.data; rsp_ready = 1'b1;
        model_load = v.load; model_init = v.init; mlen = v.mlen;
        for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
            @(negedge WRCK);
            cmd_valid = 1'b0;
            model_load = 1'b0;
            if ($countones({CaptureWR, ShiftWR, UpdateWR}) > 1) excl_ok = 1'b0;
            if ((CaptureWR || ShiftWR || UpdateWR) && (SelectWIR !== (v.op == 2'b00)))
                sel_ok = 1'b0;
            if (!ShiftWR && WSI) wsi_ok = 1'b0;
            if (CaptureWR) ncap++;
            if (UpdateWR) nupd++;
            if (ShiftWR) begin
                if (nshift < 20 && WSI !== v.data[nshift]) wsi_ok = 1'b0;
                nshift++;
            end
            if (rsp_valid) begin
                lat = cyc;
                done = 1'b1;
                chk("rsp_data", 32'(rsp_data), 32'(v.exp_rsp));
            end
        end
        chk("rsp_seen", 32'(done), 32'd1);
        chk("latency", 32'(lat), 32'(v.exp_shifts + 3));
        chk("capture_count", 32'(ncap), 32'd1);
        chk("shift_count", 32'(nshift), 32'(v.exp_shifts));
        chk("update_count", 32'(nupd), 32'd1);
        chk("wsi_sequence", 32'(wsi_ok), 32'd1);
        chk("select_wir", 32'(sel_ok), 32'd1);
        chk("strobe_exclusive", 32'(excl_ok), 32'd1);
        @(negedge WRCK);
        chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
        chk("ready_after_rsp", 32'(cmd_ready), 32'd1);
    endtask

    vec_t vecs[6];

    initial begin
        logic ok, seen, upd_seen;
        int n;

        vecs[0] = '{2'b00, 5'd3,  20'h00005, 1'b1, 3,  20'h00002, 20'h00002, 3};
        vecs[1] = '{2'b01, 5'd20, 20'hA5C3E, 1'b1, 20, 20'h0F0F0, 20'h0F0F0, 20};
        vecs[2] = '{2'b01, 5'd20, 20'h12345, 1'b0, 20, 20'h00000, 20'hA5C3E, 20};
        vecs[3] = '{2'b01, 5'd0,  20'hFFFFF, 1'b0, 20, 20'h00000, 20'h00000, 0};
        vecs[4] = '{2'b01, 5'd31, 20'hFEDCB, 1'b0, 20, 20'h00000, 20'h12345, 20};
        vecs[5] = '{2'b00, 5'd5,  20'h00013, 1'b1, 5,  20'h0000C, 20'h0000C, 5};

        // Reset state
        repeat (3) @(negedge WRCK);
        chk("rst_outputs", 32'({cmd_ready, rsp_valid, SelectWIR, CaptureWR, ShiftWR, UpdateWR,
                                WRSTN, WSI, busy}), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        WRST = 1'b0;
        @(negedge WRCK);
        chk("post_rst_ready", 32'(cmd_ready), 32'd1);
        chk("post_rst_wrstn", 32'(WRSTN), 32'd1);
        chk("post_rst_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 6; i++) run_scan(vecs[i]);

        // Backpressure: 4-bit register holding 4'h6, consumer stalls for 10 cycles
        @(negedge WRCK);
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_len = 5'd4; cmd_data = 20'h0000A;
        rsp_ready = 1'b0; model_load = 1'b1; model_init = 20'h00006; mlen = 4;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge WRCK);
            cmd_valid = 1'b0; model_load = 1'b0;
            seen = rsp_valid;
        end
        chk("bp_rsp_seen", 32'(seen), 32'd1);
        chk("bp_rsp_data", 32'(rsp_data), 32'h6);
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_len = 5'd0;
        ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge WRCK);
            if (!rsp_valid || rsp_data !== 20'h6 || cmd_ready || !WRSTN || !busy) ok = 1'b0;
        end
        chk("bp_stable", 32'(ok), 32'd1);
        cmd_valid = 1'b0; rsp_ready = 1'b1;
        @(negedge WRCK);
        chk("bp_rsp_drop", 32'(rsp_valid), 32'd0);
        chk("bp_ready_back", 32'(cmd_ready), 32'd1);
        chk("bp_cmd_not_taken", 32'(WRSTN), 32'd1);

        // Wrapper reset command: WRSTN low for exactly two cycles, response word untouched
        cmd_valid = 1'b1; cmd_op = 2'b10;
        n = 0; ok = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge WRCK);
            cmd_valid = 1'b0;
            if (!WRSTN) n++;
            if (rsp_valid || CaptureWR || ShiftWR || UpdateWR) ok = 1'b0;
        end
        chk("wreset_low_cycles", 32'(n), 32'd2);
        chk("wreset_quiet", 32'(ok), 32'd1);
        chk("wreset_rsp_kept", 32'(rsp_data), 32'h6);

        // Reserved op: consumed without any activity
        chk("noop_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_op = 2'b11;
        ok = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge WRCK);
            cmd_valid = 1'b0;
            if (busy || rsp_valid || CaptureWR || ShiftWR || UpdateWR || !WRSTN || !cmd_ready)
                ok = 1'b0;
        end
        chk("noop_quiet", 32'(ok), 32'd1);

        // Reset on shift cycle 7 of a 20-bit scan
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_len = 5'd20; cmd_data = 20'hFFFFF;
        model_load = 1'b1; model_init = 20'h00000; mlen = 20;
        n = 0; seen = 1'b0; upd_seen = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            @(negedge WRCK);
            cmd_valid = 1'b0; model_load = 1'b0;
            if (UpdateWR) upd_seen = 1'b1;
            if (ShiftWR) begin
                if (n == 7) begin
                    WRST = 1'b1;
                    seen = 1'b1;
                end
                n++;
            end
        end
        chk("midrst_reached", 32'(seen), 32'd1);
        @(negedge WRCK);
        chk("midrst_strobes", 32'({SelectWIR, CaptureWR, ShiftWR, UpdateWR, WSI, busy}), 32'd0);
        chk("midrst_wrstn", 32'(WRSTN), 32'd0);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        WRST = 1'b0;
        @(negedge WRCK);
        chk("midrst_idle_ready", 32'(cmd_ready), 32'd1);
        chk("midrst_idle_wrstn", 32'(WRSTN), 32'd1);
        for (int c = 0; c < 6; c++) begin
            @(negedge WRCK);
            if (UpdateWR || rsp_valid || busy) upd_seen = 1'b1;
        end
        chk("midrst_no_update", 32'(upd_seen), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
